// File: rtl/spi_controller.sv
// Mode-0 SPI master, MSB first, one DATA_WIDTH_SPI-bit exchange per request.
// Frame: LEAD (HALF), 2*DATA_WIDTH_SPI sclk edges, a final low half-period, TRAIL (HALF), GAP (HALF).
module spi_controller #(
  parameter int CLK_FPGA       = 50_000_000,
  parameter int CLK_SPI        = 5_000_000,
  parameter int DATA_WIDTH_SPI = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable_spi,
  input  logic [DATA_WIDTH_SPI-1:0] tx_byte,
  input  logic                      miso,
  output logic                      sclk,
  output logic                      ss,
  output logic                      mosi,
  output logic [DATA_WIDTH_SPI-1:0] rx_byte,
  output logic                      busy,
  output logic                      complete
);

  localparam int HALF = CLK_FPGA / (2 * CLK_SPI);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int EW   = $clog2(2 * DATA_WIDTH_SPI + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(HALF - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH_SPI);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_GAP
  } state_e;

  state_e                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [EW-1:0]             edge_q;
  logic [DATA_WIDTH_SPI-1:0] tx_q;
  logic [DATA_WIDTH_SPI-1:0] rx_q;
  logic                      sclk_q;
  logic                      ss_q;
  logic                      mosi_q;
  logic [DATA_WIDTH_SPI-1:0] rx_byte_q;
  logic                      busy_q;
  logic                      complete_q;

  // Frame sequencer; reset_n high is the (synchronous) reset condition.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      rx_byte_q  <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sclk_q <= 1'b0;
          ss_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          edge_q <= '0;
          if (enable_spi) begin
            tx_q    <= tx_byte;
            ss_q    <= 1'b0;
            busy_q  <= 1'b1;
            mosi_q  <= tx_byte[DATA_WIDTH_SPI-1];
            state_q <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[DATA_WIDTH_SPI-2:0], miso};
            edge_q  <= EW'(1);
            state_q <= S_XFER;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_XFER: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            // After the last fall, one more low half-period elapses before TRAIL.
            if (edge_q == EDGE_LAST) begin
              state_q <= S_TRAIL;
            end else begin
              edge_q <= edge_q + 1'b1;
              sclk_q <= ~sclk_q;
              if (sclk_q) begin
                if (edge_q != EDGE_LAST - 1'b1) begin
                  tx_q   <= tx_q << 1;
                  mosi_q <= tx_q[DATA_WIDTH_SPI-2];
                end else begin
                  mosi_q <= mosi_q;
                end
              end else begin
                rx_q <= {rx_q[DATA_WIDTH_SPI-2:0], miso};
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_TRAIL: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q      <= '0;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            rx_byte_q  <= rx_q;
            complete_q <= 1'b1;
            state_q    <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sclk     = sclk_q;
  assign ss       = ss_q;
  assign mosi     = mosi_q;
  assign rx_byte  = rx_byte_q;
  assign busy     = busy_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: per-cycle frame-timeline model plus directed scenarios.
module tb_spi_controller;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable_spi = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       miso;
  logic       sclk, ss, mosi, busy, complete;
  logic [7:0] rx_byte;

  int n_cmp = 0;
  int n_bad = 0;

  logic       loop_mode = 1'b1;
  logic [7:0] slave_pat = 8'h00;
  int         n_fall = 0;

  spi_controller dut (
    .clk(clk), .reset_n(reset_n), .enable_spi(enable_spi), .tx_byte(tx_byte),
    .miso(miso), .sclk(sclk), .ss(ss), .mosi(mosi), .rx_byte(rx_byte),
    .busy(busy), .complete(complete)
  );

  always #10 clk = ~clk;

  // Slave: presents bit 7 while deselected, advances one bit per sclk fall.
  always @(negedge sclk or posedge ss) begin
    if (ss) n_fall <= 0;
    else    n_fall <= n_fall + 1;
  end
  assign miso = loop_mode ? mosi : ((n_fall < 8) ? slave_pat[7 - n_fall] : 1'b0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model state: frame timeline measured in clk edges since E0.
  bit         in_frame = 1'b0;
  bit         on = 1'b0;
  int         d = 0;
  int         bi = 0;
  int         t = 0;
  logic [7:0] f_tx = 8'h00;
  logic [7:0] f_pat = 8'h00;
  logic       f_loop = 1'b0;
  logic [7:0] e_rx = 8'h00;
  logic       e_sclk, e_ss, e_mosi, e_busy, e_cmp;

  // Monitor state.
  logic       p_sclk = 1'b0, p_ss = 1'b1, p_mosi = 1'b0;
  int         ss_fall_t = 0, ss_rise_t = 0, ss_low_len = 0, ss_high_len = 0;
  bit         seen_rise = 1'b0, seen_sclk = 1'b0;
  int         last_rise_t = 0, sclk_period = 0;
  logic [7:0] mosi_bits = 8'h00;
  int         n_complete = 0, complete_dt = 0, n_toggle = 0;

  initial begin : model_and_compare
    forever begin
      @(posedge clk);
      t++;
      if (reset_n) begin
        in_frame = 1'b0;
        e_rx     = 8'h00;
        on       = 1'b1;
      end else if (in_frame) begin
        d++;
        if (d == 19 * H) in_frame = 1'b0;
      end else if (enable_spi) begin
        in_frame = 1'b1;
        d        = 0;
        f_tx     = tx_byte;
        f_loop   = loop_mode;
        f_pat    = slave_pat;
      end
      e_sclk = 1'b0; e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_cmp = 1'b0;
      if (in_frame) begin
        e_busy = 1'b1;
        e_ss   = (d >= 18 * H);
        e_sclk = (d >= H) && (d < 16 * H) && (((d - H) % (2 * H)) < H);
        if (d < 18 * H) begin
          bi = 7 - d / (2 * H);
          if (bi < 0) bi = 0;
          e_mosi = f_tx[bi];
        end
        if (d == 18 * H) begin
          e_cmp = 1'b1;
          e_rx  = f_loop ? f_tx : f_pat;
        end
      end
      #1;
      if (on) begin
        chk("sclk", 32'(sclk), 32'(e_sclk));
        chk("ss", 32'(ss), 32'(e_ss));
        chk("mosi", 32'(mosi), 32'(e_mosi));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("complete", 32'(complete), 32'(e_cmp));
        chk("rx_byte", 32'(rx_byte), 32'(e_rx));
        if (ss !== p_ss) begin
          if (!ss) begin
            ss_fall_t = t;
            if (seen_rise) ss_high_len = t - ss_rise_t;
          end else begin
            ss_low_len = t - ss_fall_t;
            ss_rise_t  = t;
            seen_rise  = 1'b1;
          end
        end
        if (sclk && !p_sclk) begin
          mosi_bits = {mosi_bits[6:0], mosi};
          if (seen_sclk) sclk_period = t - last_rise_t;
          last_rise_t = t;
          seen_sclk   = 1'b1;
        end
        if (complete) begin
          n_complete++;
          complete_dt = t - ss_fall_t;
        end
        if (sclk !== p_sclk || ss !== p_ss || mosi !== p_mosi) n_toggle++;
        p_sclk = sclk; p_ss = ss; p_mosi = mosi;
      end
    end
  end

  task automatic xfer_pulse(input logic [7:0] b);
    @(negedge clk);
    tx_byte    = b;
    enable_spi = 1'b1;
    @(negedge clk);
    enable_spi = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    for (int k = 0; k < maxc && busy !== 1'b0; k++) @(negedge clk);
    chk("done_in_time", 32'(busy), 32'(1'b0));
  endtask

  task automatic wait_complete(input int target, input int maxc);
    for (int k = 0; k < maxc && n_complete < target; k++) @(negedge clk);
    chk("complete_in_time", 32'(n_complete >= target), 32'(1'b1));
  endtask

  int c0;
  int tog0;

  initial begin : stimulus
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'(1'b0));
    chk("rst_ss", 32'(ss), 32'(1'b1));
    chk("rst_mosi", 32'(mosi), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_complete", 32'(complete), 32'(1'b0));
    chk("rst_rx", 32'(rx_byte), 32'h00);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback 0xCB.
    loop_mode = 1'b1;
    xfer_pulse(8'hCB);
    wait_done(200);
    chk("lb_rx", 32'(rx_byte), 32'h0000_00CB);
    chk("lb_mosi_at_rises", 32'(mosi_bits), 32'h0000_00CB);
    chk("lb_ss_low_len", 32'(ss_low_len), 32'd90);
    chk("lb_complete_at", 32'(complete_dt), 32'd90);
    chk("lb_complete_count", 32'(n_complete), 32'd1);

    // Slave drives 0xA5 while master sends 0x00.
    loop_mode = 1'b0;
    slave_pat = 8'hA5;
    xfer_pulse(8'h00);
    wait_done(200);
    chk("pat_rx", 32'(rx_byte), 32'h0000_00A5);
    chk("pat_sclk_period", 32'(sclk_period), 32'd10);
    chk("pat_mosi_at_rises", 32'(mosi_bits), 32'h00);
    chk("pat_complete_count", 32'(n_complete), 32'd2);

    // Continuous enable with tx_byte changed mid-frame.
    loop_mode = 1'b1;
    c0 = n_complete;
    @(negedge clk);
    tx_byte    = 8'h3C;
    enable_spi = 1'b1;
    repeat (20) @(negedge clk);
    tx_byte = 8'hF0;
    wait_complete(c0 + 1, 200);
    chk("cont_rx1", 32'(rx_byte), 32'h0000_003C);
    wait_complete(c0 + 2, 200);
    enable_spi = 1'b0;
    chk("cont_rx2", 32'(rx_byte), 32'h0000_00F0);
    wait_done(50);
    chk("cont_ss_gap", 32'(ss_high_len), 32'(H + 1));
    chk("cont_complete_count", 32'(n_complete - c0), 32'd2);

    // Abort at E0+40.
    c0 = n_complete;
    @(negedge clk);
    tx_byte    = 8'h5A;
    enable_spi = 1'b1;
    @(negedge clk);
    enable_spi = 1'b0;
    repeat (39) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'(1'b0));
    chk("abort_ss", 32'(ss), 32'(1'b1));
    chk("abort_sclk", 32'(sclk), 32'(1'b0));
    chk("abort_mosi", 32'(mosi), 32'(1'b0));
    chk("abort_rx", 32'(rx_byte), 32'h00);
    chk("abort_no_complete", 32'(n_complete - c0), 32'd0);
    reset_n = 1'b0;
    xfer_pulse(8'h96);
    wait_done(200);
    chk("post_abort_rx", 32'(rx_byte), 32'h0000_0096);
    chk("post_abort_complete", 32'(n_complete - c0), 32'd1);

    // Idle stability.
    tog0 = n_toggle;
    repeat (200) @(negedge clk);
    chk("idle_toggles", 32'(n_toggle - tog0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI master for a single slave (BMP280-class sensor), mode 0 (CPOL=0, CPHA=0), MSB first, one byte per transaction. It converts a level request plus a parallel byte into a framed serial exchange on SCLK/SS/MOSI/MISO. It returns the received byte with a one-cycle completion strobe. It sits between the sensor-polling FSM and the UART forwarding path.

## Interface
- CLK_FPGA, 50000000: system clock frequency, Hz.
- CLK_SPI, 5000000: target SCLK frequency, Hz.
- DATA_WIDTH_SPI, 8: bits per transaction.
- Derived: HALF = CLK_FPGA/(2*CLK_SPI), integer division. It is 5 with the defaults. It must be ≥1; the behaviour for HALF=0 is unsupported.

Ports:
- clk, input, 1: the single system clock. All logic is on the rising edge.
- reset_n, input, 1: one clock; reset is synchronous and active-high. The block is in reset while reset_n=1, despite the suffix.
- enable_spi, input, 1: transfer request, level-sensitive. It is sampled only in IDLE.
- tx_byte, input, DATA_WIDTH_SPI: byte to send. It is latched when a transfer starts.
- miso, input, 1: serial data from the slave.
- sclk, output, 1: SPI clock. It idles low.
- ss, output, 1: slave select, active low.
- mosi, output, 1: serial data to the slave, MSB first.
- rx_byte, output, DATA_WIDTH_SPI: last received byte. It holds its value until the next completion.
- busy, output, 1: high while a transaction is in progress.
- complete, output, 1: one-cycle pulse when rx_byte is updated.

## Operation
- All outputs are registered.
- Reset values: sclk=0, ss=1, mosi=0, rx_byte=0, busy=0, complete=0. Reset also sets state=IDLE and clears the counters and shift registers.
- States: IDLE, LEAD, XFER, TRAIL, GAP.
- IDLE:
  - Drives ss=1, sclk=0, busy=0.
  - When enable_spi=1, it latches tx_byte into the TX shift register and drives ss=0, busy=1, mosi=tx_byte[MSB], then moves to LEAD.
- LEAD:
  - Holds HALF cycles with sclk=0. This gives SS-to-first-edge setup.
  - It then raises sclk and moves to XFER.
- XFER:
  - sclk toggles every HALF cycles, for 2*DATA_WIDTH_SPI edges in total.
  - Rising edge: shift miso into the RX shift register LSB. Bits are received MSB first.
  - Falling edge: drive mosi with the next TX bit.
  - After the last (DATA_WIDTH_SPI-th) falling edge, mosi is unchanged and the FSM moves to TRAIL.
- TRAIL:
  - Holds HALF cycles with sclk=0 and ss=0. This is the hold time.
  - On exit it drives ss=1, mosi=0, rx_byte=RX shift register and complete=1 for one cycle, then moves to GAP.
- GAP:
  - Holds HALF cycles with ss=1 and busy=1. This is the minimum SS-high time.
  - It then moves to IDLE, where busy=0.
- If enable_spi stays high, a new transfer starts on the first IDLE cycle. Back-to-back transfers are separated by GAP + 1 cycle of ss high.
- tx_byte and enable_spi are ignored outside IDLE. Changing tx_byte mid-transfer has no effect.
- Reset asserted mid-transfer aborts immediately to the reset values. No complete pulse is produced and rx_byte is cleared.
- Only mode 0 is supported. There is no CPOL/CPHA parameter.

## Timing
- Let edge E0 be the clk edge that samples enable_spi=1 in IDLE.
- At E0: ss falls, busy rises, mosi=MSB.
- At E0+HALF: first sclk rise, which samples bit 7.
- SCLK rises at E0+HALF+2k*HALF and falls at E0+2(k+1)*HALF, for k=0..7.
- SCLK period is 2*HALF clk cycles (200 ns with the defaults). Duty cycle is 50%.
- Last sclk fall at E0+16*HALF. ss rises and complete=1 at E0+18*HALF (90 cycles, 1800 ns with the defaults).
- busy falls at E0+19*HALF+… exactly: at E0+19*HALF.
- The earliest next E0 is one cycle later.
- Slave data must be stable around the sclk rising edge. MOSI changes only on sclk falling edges or at E0, giving HALF cycles of setup before each rise.
- complete is high for exactly 1 cycle per transfer. rx_byte changes only in that same cycle.

## Test plan
- Reset: hold reset_n=1 for 3 cycles -> sclk=0, ss=1, mosi=0, busy=0, complete=0, rx_byte=0x00.
- Single transfer, loopback: tx_byte=0xCB with miso tied to mosi, pulse enable_spi for 1 cycle -> mosi shows 1,1,0,0,1,0,1,1 at the 8 rising edges; complete pulses at E0+90; rx_byte=0xCB; ss low for exactly 90 cycles.
- Slave pattern: slave model drives 0xA5 MSB-first, updating on sclk falling edges, with tx_byte=0x00 -> rx_byte=0xA5; sclk period measures 10 cycles.
- Continuous enable: hold enable_spi=1 and change tx_byte mid-transfer -> current byte is unaffected; the next transfer starts 1 cycle after busy falls; ss high ≥ HALF+1 cycles between frames; one complete pulse per frame.
- Abort: assert reset_n at cycle E0+40 -> next cycle all outputs are at reset values; no complete pulse; a subsequent transfer completes normally.
- Idle stability: enable_spi=0 for 200 cycles -> sclk, ss and mosi never toggle.
